// File: rtl/struct_pckg.sv
// ============================================================================
// Module      : struct_pckg
// Description : Shared constants, FSM state type and helper for dmem_responder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package struct_pckg;

    localparam logic [3:0] UNIT_B = 4'b0001;
    localparam logic [3:0] UNIT_H = 4'b0010;
    localparam logic [3:0] UNIT_W = 4'b0100;
    localparam logic [3:0] UNIT_D = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Byte-lane mask for an access of the given size, anchored at lane 0.
    function automatic logic [7:0] unit_mask(input logic [3:0] unit);
        logic [7:0] m;
        case (unit)
            UNIT_B:  m = 8'h01;
            UNIT_H:  m = 8'h03;
            UNIT_W:  m = 8'h0F;
            UNIT_D:  m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram_1rw.sv
// ============================================================================
// Module      : dmem_ram_1rw
// Description : Single-port 64-bit RAM with byte enables and registered read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ram_1rw #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];

    // rdata captures the pre-write contents, so read-during-write sees old data.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= r_mem[idx];
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) begin
                        r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage load/store responder with lane alignment/extension
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import struct_pckg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [3:0]  req_unit,
    input  logic        req_ext,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_is_load,
    output logic        resp_err
);

    dmem_state_t r_state, w_next;

    logic [2:0]  r_off;
    logic [3:0]  r_unit;
    logic        r_ext;

    logic        w_accept;
    logic        w_misalign;
    logic        w_range_err;
    logic        w_unit_err;
    logic        w_op_err;
    logic        w_err;
    logic [5:0]  w_shamt;
    logic [7:0]  w_mask;
    logic [63:0] w_wdata;
    logic        w_ram_en;
    logic [63:0] w_rdata;
    logic [63:0] w_lane;
    logic [63:0] w_ext_data;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign w_accept   = req_valid && req_ready;

    assign w_misalign  = ((req_unit == UNIT_H) && (req_addr[0]   != 1'b0))
                      || ((req_unit == UNIT_W) && (req_addr[1:0] != 2'b0))
                      || ((req_unit == UNIT_D) && (req_addr[2:0] != 3'b0));
    assign w_range_err = (req_addr[63:AW+3] != '0);
    assign w_unit_err  = (req_unit == 4'b0) || ((req_unit & (req_unit - 4'd1)) != 4'b0);
    assign w_op_err    = (req_rd == req_wr);
    assign w_err       = w_misalign || w_range_err || w_unit_err || w_op_err;

    assign w_shamt  = {req_addr[2:0], 3'b000};
    assign w_mask   = unit_mask(req_unit) << req_addr[2:0];
    assign w_wdata  = req_data << w_shamt;
    assign w_ram_en = w_accept && !w_err;

    dmem_ram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (req_wr),
        .be    (w_mask),
        .idx   (req_addr[AW+2:3]),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    // Load path works on the lane offset and size captured at accept.
    assign w_lane = w_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext_data = w_lane;
        case (r_unit)
            UNIT_B:  w_ext_data = r_ext ? {{56{w_lane[7]}},  w_lane[7:0]}  : {56'b0, w_lane[7:0]};
            UNIT_H:  w_ext_data = r_ext ? {{48{w_lane[15]}}, w_lane[15:0]} : {48'b0, w_lane[15:0]};
            UNIT_W:  w_ext_data = r_ext ? {{32{w_lane[31]}}, w_lane[31:0]} : {32'b0, w_lane[31:0]};
            default: w_ext_data = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_err || req_wr) ? RESP : LOAD;
                end
            end
            LOAD:    w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off        <= 3'b0;
            r_unit       <= 4'b0;
            r_ext        <= 1'b0;
            resp_data    <= 64'b0;
            resp_is_load <= 1'b0;
            resp_err     <= 1'b0;
        end else if (w_accept) begin
            r_off        <= req_addr[2:0];
            r_unit       <= req_unit;
            r_ext        <= req_ext;
            resp_data    <= 64'b0;
            resp_is_load <= req_rd && !req_wr;
            resp_err     <= w_err;
        end else if (r_state == LOAD) begin
            resp_data    <= w_ext_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder against a byte-array model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH = 512;
    localparam int NBYTES = DEPTH * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_unit;
    logic        req_ext;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_is_load;
    logic        resp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mdl [NBYTES];
    logic [63:0] last_data;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_unit     (req_unit),
        .req_ext      (req_ext),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_is_load (resp_is_load),
        .resp_err     (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed memory, size in bytes, arithmetic extension.
    task automatic model(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic [3:0] unit, input logic ext,
                         output logic err, output logic is_ld, output logic [63:0] val);
        int sz;
        int base;
        logic [63:0] v;
        case (unit)
            4'd1:    sz = 1;
            4'd2:    sz = 2;
            4'd4:    sz = 4;
            4'd8:    sz = 8;
            default: sz = 0;
        endcase
        err = (sz == 0) || (rd == wr) || (addr >= 64'(NBYTES))
           || ((sz != 0) && ((addr % 64'(sz)) != 0));
        is_ld = !err && rd;
        v = 64'b0;
        if (!err) begin
            base = int'(addr);
            for (int i = 0; i < sz; i++) begin
                if (wr) mdl[base + i] = data[8*i +: 8];
                else    v[8*i +: 8] = mdl[base + i];
            end
            if (rd && ext && v[8*sz - 1]) v = v | (~64'b0 << (8*sz));
        end
        val = is_ld ? v : 64'b0;
    endtask

    // One full request/response transaction with latency and handshake checks.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [63:0] data, input logic [3:0] unit, input logic ext);
        logic e_err, e_ld;
        logic [63:0] e_val;
        model(rd, wr, addr, data, unit, ext, e_err, e_ld, e_val);
        @(negedge clk);
        req_valid = 1'b1;
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        req_unit  = unit;
        req_ext   = ext;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rd    = 1'($urandom);
        req_wr    = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_data  = {$urandom, $urandom};
        req_unit  = 4'($urandom);
        req_ext   = 1'($urandom);
        check("req_ready_after_accept", 64'(req_ready), 64'd0);
        if (e_ld) begin
            check("load_not_yet_valid", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_err", 64'(resp_err), 64'(e_err));
        check("resp_data", resp_data, e_val);
        if (!e_err) check("resp_is_load", 64'(resp_is_load), 64'(e_ld));
        last_data = resp_data;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] held;
        logic [3:0]  u;
        logic        rd, wr;
        int          r, sz;
        logic        e_err, e_ld;
        logic [63:0] e_val;

        rst = 1'b1;
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_data = '0; req_unit = '0; req_ext = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_is_load", 64'(resp_is_load), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Give every byte used later a defined value.
        for (int w = 0; w < 16; w++) do_req(1'b0, 1'b1, 64'(w * 8), {$urandom, $urandom}, 4'b1000, 1'b0);

        do_req(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 4'b1000, 1'b0);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 4'b1000, 1'b0);
        check("tp_double_value", last_data, 64'h1122334455667788);

        do_req(1'b0, 1'b1, 64'h13, 64'h80, 4'b0001, 1'b0);
        do_req(1'b1, 1'b0, 64'h13, 64'h0, 4'b0001, 1'b1);
        check("tp_byte_sext", last_data, 64'hFFFFFFFFFFFFFF80);
        do_req(1'b1, 1'b0, 64'h13, 64'h0, 4'b0001, 1'b0);
        check("tp_byte_zext", last_data, 64'h0000000000000080);
        do_req(1'b1, 1'b0, 64'h10, 64'h0, 4'b1000, 1'b0);
        check("tp_byte_lane3", last_data, 64'h1122334480667788);

        do_req(1'b0, 1'b1, 64'h24, 64'h80000001, 4'b0100, 1'b0);
        do_req(1'b1, 1'b0, 64'h24, 64'h0, 4'b0100, 1'b1);
        check("tp_word_sext", last_data, 64'hFFFFFFFF80000001);

        do_req(1'b0, 1'b1, 64'h21, 64'hBEEF, 4'b0010, 1'b0);
        do_req(1'b1, 1'b0, 64'h20, 64'h0, 4'b1000, 1'b0);
        do_req(1'b1, 1'b1, 64'h20, 64'h0, 4'b1000, 1'b0);
        do_req(1'b1, 1'b0, 64'(NBYTES), 64'h0, 4'b1000, 1'b0);
        do_req(1'b0, 1'b0, 64'h20, 64'h0, 4'b1000, 1'b0);
        do_req(1'b1, 1'b0, 64'h20, 64'h0, 4'b0011, 1'b0);
        do_req(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 4'b0001, 1'b0);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 15);
            rd = 1'($urandom);
            wr = !rd;
            if (r == 0) wr = 1'($urandom);
            u = 4'(1 << $urandom_range(0, 3));
            if (r == 1) u = 4'($urandom);
            a = 64'($urandom_range(0, 127));
            if (r == 2) a = 64'(NBYTES + $urandom_range(0, 4095));
            if (r >= 8) begin
                sz = (u == 4'd2) ? 2 : (u == 4'd4) ? 4 : (u == 4'd8) ? 8 : 1;
                a = a & ~64'(sz - 1);
            end
            do_req(rd, wr, a, {$urandom, $urandom}, u, 1'($urandom));
        end

        // Back-pressure: response must hold while resp_ready stays low.
        model(1'b1, 1'b0, 64'h10, 64'h0, 4'b1000, 1'b0, e_err, e_ld, e_val);
        @(negedge clk);
        req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 64'h10;
        req_unit = 4'b1000; req_ext = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        held = resp_data;
        check("bp_first_data", held, e_val);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_resp_data", resp_data, e_val);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 64'(req_ready), 64'd1);
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        resp_ready = 1'b0;

        // Reset during the LOAD cycle drops the pending response.
        @(negedge clk);
        req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 64'h18;
        req_unit = 4'b1000; req_ext = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_load_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_load_ready", 64'(req_ready), 64'd1);
        do_req(1'b1, 1'b0, 64'h18, 64'h0, 4'b1000, 1'b0);
        do_req(1'b1, 1'b0, 64'h16, 64'h0, 4'b0010, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
